// File: rtl/pll_reconfig_ctrl.sv
// Video PLL sequencer: reset pulse, lock qualification and runtime NTSC/PAL
// retuning through the Altera pll_reconfig Avalon-MM management port.
module pll_reconfig_ctrl #(
  parameter int          RST_CYCLES   = 16,
  parameter int          LOCK_STABLE  = 1024,
  parameter int          LOCK_TIMEOUT = 2000000,
  parameter logic [31:0] N_VAL        = 32'h0001_0000,
  parameter logic [31:0] M_VAL        = 32'h0002_0605,
  parameter logic [31:0] C0_VAL       = 32'h0000_0505,
  parameter logic [31:0] K_NTSC       = 32'h745D_1745,
  parameter logic [31:0] K_PAL        = 32'h599E_D7C7
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        pal,
  input  logic        pll_locked,
  output logic        pll_rst,
  output logic        core_reset_n,
  output logic        busy,
  output logic        cur_pal,
  output logic [5:0]  mgmt_address,
  output logic        mgmt_write,
  output logic        mgmt_read,
  output logic [31:0] mgmt_writedata,
  input  logic [31:0] mgmt_readdata,
  input  logic        mgmt_waitrequest
);

  typedef enum logic [3:0] {
    PRST,
    WAIT_LOCK,
    RUN,
    W_MODE,
    W_N,
    W_M,
    W_K,
    W_C,
    W_START,
    POLL
  } state_t;

  localparam logic [5:0] A_MODE   = 6'h00;
  localparam logic [5:0] A_STATUS = 6'h01;
  localparam logic [5:0] A_START  = 6'h02;
  localparam logic [5:0] A_N      = 6'h03;
  localparam logic [5:0] A_M      = 6'h04;
  localparam logic [5:0] A_C      = 6'h05;
  localparam logic [5:0] A_K      = 6'h07;

  localparam logic [31:0] RST_LAST     = 32'(RST_CYCLES - 1);
  localparam logic [31:0] STABLE_LAST  = 32'(LOCK_STABLE - 1);
  localparam logic [31:0] TIMEOUT_LAST = 32'(LOCK_TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [31:0] tmr_q, tmr_d;
  logic [31:0] stable_q, stable_d;
  logic        tgt_q, tgt_d;
  logic        cur_pal_d;
  logic        write_d, read_d;
  logic [5:0]  addr_d;
  logic [31:0] wdata_d;
  logic        lock_p0, lock_p1;
  logic        lock_s;
  logic        unused_readdata;

  // Only the status bit of the management readback carries meaning here.
  assign unused_readdata = ^mgmt_readdata[31:1];

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  function automatic state_t next_write(input state_t s);
    case (s)
      W_MODE:  return W_N;
      W_N:     return W_M;
      W_M:     return W_K;
      W_K:     return W_C;
      W_C:     return W_START;
      default: return POLL;
    endcase
  endfunction

  function automatic logic [5:0] write_addr(input state_t s);
    case (s)
      W_MODE:  return A_MODE;
      W_N:     return A_N;
      W_M:     return A_M;
      W_K:     return A_K;
      W_C:     return A_C;
      default: return A_START;
    endcase
  endfunction

  function automatic logic [31:0] write_data(input state_t s, input logic p);
    case (s)
      W_N:     return N_VAL;
      W_M:     return M_VAL;
      W_K:     return p ? K_PAL : K_NTSC;
      W_C:     return C0_VAL;
      default: return 32'd0;
    endcase
  endfunction

  // Lock synchroniser, p0 -> p1; held clear while the PLL is in reset so a
  // stale lock from before the pulse is never counted towards qualification.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lock_p0 <= 1'b0;
      lock_p1 <= 1'b0;
    end else if (pll_rst) begin
      lock_p0 <= 1'b0;
      lock_p1 <= 1'b0;
    end else begin
      lock_p0 <= pll_locked;
      lock_p1 <= lock_p0;
    end
  end

  assign lock_s = lock_p1;

  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q;
    stable_d  = stable_q;
    tgt_d     = tgt_q;
    cur_pal_d = cur_pal;
    write_d   = mgmt_write;
    read_d    = mgmt_read;
    addr_d    = mgmt_address;
    wdata_d   = mgmt_writedata;

    case (state_q)
      PRST: begin
        if (tmr_q >= RST_LAST) begin
          state_d = WAIT_LOCK;
        end else begin
          tmr_d = sat_inc(tmr_q);
        end
      end

      WAIT_LOCK: begin
        tmr_d    = sat_inc(tmr_q);
        stable_d = lock_s ? sat_inc(stable_q) : 32'd0;
        if (lock_s && (stable_q >= STABLE_LAST)) begin
          state_d = RUN;
        end else if (tmr_q >= TIMEOUT_LAST) begin
          // A PLL reset restores the power-on NTSC configuration.
          state_d   = PRST;
          cur_pal_d = 1'b0;
        end
      end

      RUN: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
        end else if (pal != cur_pal) begin
          tgt_d   = pal;
          state_d = W_MODE;
        end
      end

      POLL: begin
        if (!mgmt_read) begin
          read_d  = 1'b1;
          addr_d  = A_STATUS;
          wdata_d = 32'd0;
        end else if (!mgmt_waitrequest) begin
          read_d = 1'b0;
          if (mgmt_readdata[0]) begin
            cur_pal_d = tgt_q;
            state_d   = WAIT_LOCK;
          end
        end
      end

      default: begin
        // Each write state issues one access; the strobe is low for the
        // first cycle of every state, which gives the idle gap between writes.
        if (!mgmt_write) begin
          write_d = 1'b1;
          addr_d  = write_addr(state_q);
          wdata_d = write_data(state_q, tgt_q);
        end else if (!mgmt_waitrequest) begin
          write_d = 1'b0;
          state_d = next_write(state_q);
        end
      end
    endcase

    if (state_d != state_q) begin
      tmr_d    = 32'd0;
      stable_d = 32'd0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= PRST;
      tmr_q          <= 32'd0;
      stable_q       <= 32'd0;
      tgt_q          <= 1'b0;
      cur_pal        <= 1'b0;
      mgmt_write     <= 1'b0;
      mgmt_read      <= 1'b0;
      mgmt_address   <= 6'd0;
      mgmt_writedata <= 32'd0;
      pll_rst        <= 1'b1;
      core_reset_n   <= 1'b0;
      busy           <= 1'b1;
    end else begin
      state_q        <= state_d;
      tmr_q          <= tmr_d;
      stable_q       <= stable_d;
      tgt_q          <= tgt_d;
      cur_pal        <= cur_pal_d;
      mgmt_write     <= write_d;
      mgmt_read      <= read_d;
      mgmt_address   <= addr_d;
      mgmt_writedata <= wdata_d;
      pll_rst        <= (state_d == PRST);
      core_reset_n   <= (state_d == RUN);
      busy           <= (state_d != RUN);
    end
  end

endmodule
